// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the byte-lane data memory.
// Port A (CPU load/store) and port B (DMA/IO copy) share one memory port.
// Each access runs grant (IDLE/RESP) -> ISSUE -> RESP. Misaligned or illegal
// sizes are caught before issue, so they never raise Mem_write.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   {A,B}_req/we/addr/wdata/width/sext   request fields, held until gnt
//   {A,B}_gnt                pulse in the cycle the request fields are sampled
//   {A,B}_done/rdata/err     response pulse, two cycles after gnt
//   Mem_write/addr/wdata/width/sext      memory command
//   Mem_rdata                extended read data, valid the cycle after issue
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter bit          FIXED_PRIO_A = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  A_req,
  input  logic                  A_we,
  input  logic [ADDR_WIDTH-1:0] A_addr,
  input  logic [DATA_WIDTH-1:0] A_wdata,
  input  logic [1:0]            A_width,
  input  logic                  A_sext,
  output logic                  A_gnt,
  output logic                  A_done,
  output logic [DATA_WIDTH-1:0] A_rdata,
  output logic                  A_err,
  input  logic                  B_req,
  input  logic                  B_we,
  input  logic [ADDR_WIDTH-1:0] B_addr,
  input  logic [DATA_WIDTH-1:0] B_wdata,
  input  logic [1:0]            B_width,
  input  logic                  B_sext,
  output logic                  B_gnt,
  output logic                  B_done,
  output logic [DATA_WIDTH-1:0] B_rdata,
  output logic                  B_err,
  output logic                  Mem_write,
  output logic [ADDR_WIDTH-1:0] Mem_addr,
  output logic [DATA_WIDTH-1:0] Mem_wdata,
  output logic [1:0]            Mem_width,
  output logic                  Mem_sext,
  input  logic [DATA_WIDTH-1:0] Mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Size/alignment check: half needs addr[0]=0, word needs addr[1:0]=0, 10 is illegal.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lsb);
    logic mis;
    case (width)
      2'b00:   mis = 1'b0;
      2'b01:   mis = lsb[0];
      2'b11:   mis = (lsb != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  logic [1:0]            state_q, state_d;
  logic                  prio_b_q, prio_b_d;     // 1: B wins the next tie
  logic                  owner_b_q, owner_b_d;
  logic                  we_q, we_d;
  logic                  mis_q, mis_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]            mem_width_q, mem_width_d;
  logic                  mem_sext_q, mem_sext_d;
  logic                  a_done_q, a_done_d, b_done_q, b_done_d;
  logic                  a_err_q, a_err_d, b_err_q, b_err_d;
  logic                  a_rd_en_q, a_rd_en_d, b_rd_en_q, b_rd_en_d;

  logic                  arb_window, pick_b, grant;
  logic                  sel_we, sel_sext, sel_mis;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [1:0]            sel_width;

  // Arbitration: only in IDLE/RESP, suppressed while reset is asserted.
  assign arb_window = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign pick_b     = B_req && (!A_req || (!FIXED_PRIO_A && prio_b_q));
  assign grant      = arb_window && (A_req || B_req) && !reset;
  assign A_gnt      = grant && !pick_b;
  assign B_gnt      = grant && pick_b;

  assign sel_we    = pick_b ? B_we    : A_we;
  assign sel_addr  = pick_b ? B_addr  : A_addr;
  assign sel_wdata = pick_b ? B_wdata : A_wdata;
  assign sel_width = pick_b ? B_width : A_width;
  assign sel_sext  = pick_b ? B_sext  : A_sext;
  assign sel_mis   = is_misaligned(sel_width, sel_addr[1:0]);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    prio_b_d    = prio_b_q;
    owner_b_d   = owner_b_q;
    we_d        = we_q;
    mis_d       = mis_q;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_width_d = mem_width_q;
    mem_sext_d  = mem_sext_q;
    a_done_d    = 1'b0;
    b_done_d    = 1'b0;
    a_err_d     = 1'b0;
    b_err_d     = 1'b0;
    a_rd_en_d   = 1'b0;
    b_rd_en_d   = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        state_d   = ST_RESP;
        a_done_d  = !owner_b_q;
        b_done_d  = owner_b_q;
        a_err_d   = !owner_b_q && mis_q;
        b_err_d   = owner_b_q && mis_q;
        a_rd_en_d = !owner_b_q && !we_q && !mis_q;
        b_rd_en_d = owner_b_q && !we_q && !mis_q;
      end
      default: begin
        if (grant) begin
          state_d     = ST_ISSUE;
          prio_b_d    = !pick_b;
          owner_b_d   = pick_b;
          we_d        = sel_we;
          mis_d       = sel_mis;
          mem_write_d = sel_we && !sel_mis;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_width_d = sel_width;
          mem_sext_d  = sel_sext;
        end else begin
          state_d     = ST_IDLE;
          owner_b_d   = 1'b0;
          we_d        = 1'b0;
          mis_d       = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_width_d = 2'b00;
          mem_sext_d  = 1'b0;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prio_b_q    <= 1'b0;
      owner_b_q   <= 1'b0;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_width_q <= 2'b00;
      mem_sext_q  <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
      a_rd_en_q   <= 1'b0;
      b_rd_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_b_q    <= prio_b_d;
      owner_b_q   <= owner_b_d;
      we_q        <= we_d;
      mis_q       <= mis_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_width_q <= mem_width_d;
      mem_sext_q  <= mem_sext_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      a_err_q     <= a_err_d;
      b_err_q     <= b_err_d;
      a_rd_en_q   <= a_rd_en_d;
      b_rd_en_q   <= b_rd_en_d;
    end
  end

  // Reset in the ISSUE cycle must not let the pending write reach the RAM.
  assign Mem_write = mem_write_q && !reset;
  assign Mem_addr  = mem_addr_q;
  assign Mem_wdata = mem_wdata_q;
  assign Mem_width = mem_width_q;
  assign Mem_sext  = mem_sext_q;

  // Read data only exists in the response cycle, so it is gated by a registered enable.
  assign A_done  = a_done_q;
  assign A_err   = a_err_q;
  assign A_rdata = a_rd_en_q ? Mem_rdata : '0;
  assign B_done  = b_done_q;
  assign B_err   = b_err_q;
  assign B_rdata = b_rd_en_q ? Mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-lane RAM model and a response scoreboard.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        A_req = 1'b0, A_we = 1'b0, A_sext = 1'b0;
  logic [31:0] A_addr = '0, A_wdata = '0;
  logic [1:0]  A_width = 2'b00;
  logic        B_req = 1'b0, B_we = 1'b0, B_sext = 1'b0;
  logic [31:0] B_addr = '0, B_wdata = '0;
  logic [1:0]  B_width = 2'b00;
  logic        A_gnt, A_done, A_err, B_gnt, B_done, B_err;
  logic [31:0] A_rdata, B_rdata;
  logic        Mem_write, Mem_sext;
  logic [31:0] Mem_addr, Mem_wdata, Mem_rdata;
  logic [1:0]  Mem_width;

  logic        fp_A_gnt, fp_A_done, fp_A_err, fp_B_gnt, fp_B_done, fp_B_err;
  logic [31:0] fp_A_rdata, fp_B_rdata, fp_Mem_addr, fp_Mem_wdata;
  logic        fp_Mem_write, fp_Mem_sext;
  logic [1:0]  fp_Mem_width;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  logic [7:0]  mem [0:255];
  logic [31:0] mem_rd_q = '0;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO_A(1'b0)) dut (
    .clock(clock), .reset(reset),
    .A_req(A_req), .A_we(A_we), .A_addr(A_addr), .A_wdata(A_wdata), .A_width(A_width), .A_sext(A_sext),
    .A_gnt(A_gnt), .A_done(A_done), .A_rdata(A_rdata), .A_err(A_err),
    .B_req(B_req), .B_we(B_we), .B_addr(B_addr), .B_wdata(B_wdata), .B_width(B_width), .B_sext(B_sext),
    .B_gnt(B_gnt), .B_done(B_done), .B_rdata(B_rdata), .B_err(B_err),
    .Mem_write(Mem_write), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata), .Mem_width(Mem_width),
    .Mem_sext(Mem_sext), .Mem_rdata(Mem_rdata)
  );

  // Fixed-priority instance shares the request inputs; only its grants are observed.
  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO_A(1'b1)) dut_fp (
    .clock(clock), .reset(reset),
    .A_req(A_req), .A_we(A_we), .A_addr(A_addr), .A_wdata(A_wdata), .A_width(A_width), .A_sext(A_sext),
    .A_gnt(fp_A_gnt), .A_done(fp_A_done), .A_rdata(fp_A_rdata), .A_err(fp_A_err),
    .B_req(B_req), .B_we(B_we), .B_addr(B_addr), .B_wdata(B_wdata), .B_width(B_width), .B_sext(B_sext),
    .B_gnt(fp_B_gnt), .B_done(fp_B_done), .B_rdata(fp_B_rdata), .B_err(fp_B_err),
    .Mem_write(fp_Mem_write), .Mem_addr(fp_Mem_addr), .Mem_wdata(fp_Mem_wdata), .Mem_width(fp_Mem_width),
    .Mem_sext(fp_Mem_sext), .Mem_rdata(32'h0)
  );

  // Byte-lane RAM: synchronous read with width/sign extension, little-endian.
  function automatic logic [31:0] mem_read(input logic [7:0] a, input logic [1:0] w, input logic s);
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] v;
    b0 = mem[a];
    b1 = mem[a + 8'd1];
    b2 = mem[a + 8'd2];
    b3 = mem[a + 8'd3];
    case (w)
      2'b00:   v = s ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   v = s ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
      default: v = {b3, b2, b1, b0};
    endcase
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end

  always @(posedge clock) begin
    mem_rd_q <= mem_read(Mem_addr[7:0], Mem_width, Mem_sext);
    if (Mem_write) begin
      mem[Mem_addr[7:0]] <= Mem_wdata[7:0];
      if (Mem_width != 2'b00) mem[Mem_addr[7:0] + 8'd1] <= Mem_wdata[15:8];
      if (Mem_width == 2'b11) begin
        mem[Mem_addr[7:0] + 8'd2] <= Mem_wdata[23:16];
        mem[Mem_addr[7:0] + 8'd3] <= Mem_wdata[31:24];
      end
    end
  end
  assign Mem_rdata = mem_rd_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({A_gnt, B_gnt, A_done, B_done, A_err, B_err, Mem_write, Mem_sext, Mem_width}), 32'd0);
    chk({tag, "_data"}, A_rdata | B_rdata | Mem_addr | Mem_wdata, 32'd0);
  endtask

  // Response monitor: every done pulse pops the oldest expected response.
  always begin : monitor
    exp_t        e;
    logic [31:0] rd;
    logic        er;
    @(negedge clock);
    #1;
    if (A_done || B_done) begin
      chk("single_done", 32'(A_done && B_done), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'({A_done, B_done}), 32'd0);
      end else begin
        e  = sb.pop_front();
        rd = e.port ? B_rdata : A_rdata;
        er = e.port ? B_err : A_err;
        chk("done_port", 32'(B_done), 32'(e.port));
        chk("rdata", rd, e.rdata);
        chk("err", 32'(er), 32'(e.err));
      end
    end
    if (!A_done) chk("a_cleared", A_rdata | 32'(A_err), 32'd0);
    if (!B_done) chk("b_cleared", B_rdata | 32'(B_err), 32'd0);
  end

  task automatic drive(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] w, input logic s);
    if (port) begin
      B_req = 1'b1; B_we = we; B_addr = addr; B_wdata = wdata; B_width = w; B_sext = s;
    end else begin
      A_req = 1'b1; A_we = we; A_addr = addr; A_wdata = wdata; A_width = w; A_sext = s;
    end
  endtask

  // One uncontended access from IDLE: gnt at N, issue at N+1, done at N+2.
  task automatic access(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] w, input logic s,
                        input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    @(negedge clock);
    drive(port, we, addr, wdata, w, s);
    #2;
    chk("gnt", 32'(port ? B_gnt : A_gnt), 32'd1);
    chk("gnt_other", 32'(port ? A_gnt : B_gnt), 32'd0);
    chk("grant_cycle_write", 32'(Mem_write), 32'd0);
    e.port = port; e.rdata = exp_rd; e.err = exp_err;
    sb.push_back(e);
    @(negedge clock);
    if (port) B_req = 1'b0; else A_req = 1'b0;
    #2;
    chk("issue_write", 32'(Mem_write), 32'(we && !exp_err));
    chk("issue_addr", Mem_addr, addr);
    @(negedge clock);
    #2;
    chk("resp_write", 32'(Mem_write), 32'd0);
    chk("resp_done_seen", 32'(sb.size()), 32'd0);
  endtask

  // Both ports request word reads continuously until n grants have been made.
  task automatic contend(input int n, input logic [31:0] a_addr, input logic [31:0] a_exp,
                         input logic [31:0] b_addr, input logic [31:0] b_exp, input logic check_fp);
    int   ng, cyc, fpa, fpb;
    logic q_port[$];
    int   q_cyc[$];
    exp_t e;
    ng = 0; cyc = 0; fpa = 0; fpb = 0;
    @(negedge clock);
    drive(1'b0, 1'b0, a_addr, 32'h0, 2'b11, 1'b0);
    drive(1'b1, 1'b0, b_addr, 32'h0, 2'b11, 1'b0);
    while (ng < n && cyc < 20) begin
      #2;
      if (A_gnt) begin
        e.port = 1'b0; e.rdata = a_exp; e.err = 1'b0;
        sb.push_back(e); q_port.push_back(1'b0); q_cyc.push_back(cyc); ng++;
      end
      if (B_gnt) begin
        e.port = 1'b1; e.rdata = b_exp; e.err = 1'b0;
        sb.push_back(e); q_port.push_back(1'b1); q_cyc.push_back(cyc); ng++;
      end
      if (fp_A_gnt) fpa++;
      if (fp_B_gnt) fpb++;
      @(negedge clock);
      cyc++;
    end
    A_req = 1'b0;
    B_req = 1'b0;
    chk("contend_count", 32'(ng), 32'(n));
    for (int i = 0; i < q_port.size(); i++) begin
      chk("contend_order", 32'(q_port[i]), 32'(i % 2));
      if (i > 0) chk("contend_spacing", 32'(q_cyc[i] - q_cyc[i-1]), 32'd2);
    end
    if (check_fp) begin
      chk("fixed_prio_a_grants", 32'(fpa), 32'(n));
      chk("fixed_prio_b_grants", 32'(fpb), 32'd0);
    end
    repeat (2) @(negedge clock);
    #2;
    chk("contend_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // Reset state
    repeat (3) @(negedge clock);
    #2;
    chk_all_zero("in_reset");
    reset = 1'b0;
    @(negedge clock);
    #2;
    chk_all_zero("idle");

    // Word write then read
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 1'b0, 32'h0, 1'b0);
    access(1'b0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDEADBEEF, 1'b0);

    // Byte write 0x80 @0x13, then sign-extended and zero-extended byte reads
    access(1'b0, 1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0, 32'h0, 1'b0);
    access(1'b0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0);
    access(1'b0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 32'h00000080, 1'b0);
    access(1'b1, 1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 32'hFFFF80AD, 1'b0);

    // Misaligned and illegal accesses
    access(1'b0, 1'b1, 32'h20, 32'h11223344, 2'b11, 1'b0, 32'h0, 1'b0);
    access(1'b1, 1'b1, 32'h21, 32'h0000AAAA, 2'b01, 1'b0, 32'h0, 1'b1);
    access(1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 1'b0, 32'h11223344, 1'b0);
    access(1'b0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
    access(1'b0, 1'b1, 32'h20, 32'h99999999, 2'b10, 1'b0, 32'h0, 1'b1);
    access(1'b1, 1'b0, 32'h22, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
    access(1'b0, 1'b0, 32'h20, 32'h0, 2'b11, 1'b0, 32'h11223344, 1'b0);

    // Contention from a fresh reset: round-robin A,B,A,B; fixed priority A only
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    contend(4, 32'h10, 32'h80ADBEEF, 32'h20, 32'h11223344, 1'b1);

    // Reset during the ISSUE cycle of an A write
    access(1'b0, 1'b1, 32'h30, 32'h55555555, 2'b11, 1'b0, 32'h0, 1'b0);
    @(negedge clock);
    drive(1'b0, 1'b1, 32'h30, 32'h12345678, 2'b11, 1'b0);
    #2;
    chk("rst_gnt", 32'(A_gnt), 32'd1);
    e.port = 1'b0; e.rdata = 32'h0; e.err = 1'b0;
    sb.push_back(e);
    @(negedge clock);
    A_req = 1'b0;
    reset = 1'b1;
    sb.delete();
    #2;
    chk("rst_issue_write", 32'(Mem_write), 32'd0);
    @(negedge clock);
    #2;
    chk_all_zero("after_rst");
    reset = 1'b0;
    @(negedge clock);
    #2;
    chk_all_zero("post_rst_idle");
    contend(2, 32'h30, 32'h55555555, 32'h10, 32'h80ADBEEF, 1'b0);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
